// File: rtl/mode4_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mode4_seq_pkg
//  Brief    : Shared state encoding and tree-depth constant for the mode4
//             adder-tree sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package mode4_seq_pkg;

    // Sequencer states (3-bit encoding shared with debug tooling)
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Number of registered levels in the 4-input adder tree
    localparam int TREE_DEPTH = 3;

endpackage
`default_nettype wire

// File: rtl/mode4_run_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mode4_run_pipe
//  Brief    : Valid shift register that follows accepted groups down the
//             adder tree and produces the run enables for the later levels.
//  Revision : 1.0 - initial release
// ============================================================================
module mode4_run_pipe (
    input  logic clk,
    input  logic i_clr_n,
    input  logic i_accept,
    output logic o_stage1_run,
    output logic o_stage0_run
);
    import mode4_seq_pkg::*;

    // One valid flag per adder level after the input pair registers
    localparam int c_DEPTH = TREE_DEPTH - 1;

    logic [c_DEPTH-1:0] r_valid;

    // Shift the accept flag one level per cycle; bubbles travel as zeros
    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_valid <= '0;
        end else begin
            r_valid <= {r_valid[c_DEPTH-2:0], i_accept};
        end
    end

    assign o_stage1_run = r_valid[0];
    assign o_stage0_run = r_valid[c_DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mode4_tree_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mode4_tree_sequencer
//  Brief    : Sequences a job of N four-word groups through the 3-stage
//             pipelined FP adder tree: clears the accumulator, accepts groups
//             with valid/ready, drives per-stage run enables and pulses done
//             once the final sum sits at the tree output.
//  Options  : MODE4_TREE_SEQ_PERF_EN adds busy/stall performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module mode4_tree_sequencer #(
    parameter int CNT_W  = 8
`ifdef MODE4_TREE_SEQ_PERF_EN
    ,
    parameter int PERF_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_groups,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             stage2_run,
    output logic             stage1_run,
    output logic             stage0_run,
    output logic             tree_clear,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] groups_accepted
`ifdef MODE4_TREE_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_busy_cycles,
    output logic [PERF_W-1:0] perf_stall_cycles
`endif
);
    import mode4_seq_pkg::*;

    state_t             r_state;
    logic [CNT_W-1:0]   r_n_q;
    logic [CNT_W-1:0]   r_groups;
    logic               r_tree_clear;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_v1;
    logic               w_v0;

    // Group transfer happens only while feeding and upstream is valid
    assign w_accept = in_valid && (r_state == ST_FEED);

    mode4_run_pipe u_run_pipe (
        .clk          (clk),
        .i_clr_n      (reset),
        .i_accept     (w_accept),
        .o_stage1_run (w_v1),
        .o_stage0_run (w_v0)
    );

    // Job control FSM with registered clear/busy/done and group counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_n_q        <= '0;
            r_groups     <= '0;
            r_tree_clear <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_tree_clear <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_n_q        <= num_groups;
                        r_groups     <= '0;
                        r_tree_clear <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    // A zero-length job skips straight to done with a cleared tree
                    if (r_n_q != '0) begin
                        r_state <= ST_FEED;
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_FEED: begin
                    if (w_accept) begin
                        r_groups <= r_groups + 1'b1;
                        if (r_groups == r_n_q - 1'b1) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Once the second level is empty, the last add is in stage 0 now
                    if (!w_v1) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready        = (r_state == ST_FEED);
    assign stage2_run      = w_accept;
    assign stage1_run      = w_v1;
    assign stage0_run      = w_v0;
    assign tree_clear      = r_tree_clear;
    assign busy            = r_busy;
    assign done            = r_done;
    assign groups_accepted = r_groups;

`ifdef MODE4_TREE_SEQ_PERF_EN
    logic [PERF_W-1:0] r_perf_busy;
    logic [PERF_W-1:0] r_perf_stall;

    // Saturating busy and stall counters, restarted by each accepted start
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_busy && (r_perf_busy != '1)) begin
                r_perf_busy <= r_perf_busy + 1'b1;
            end
            if ((r_state == ST_FEED) && !in_valid && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign perf_busy_cycles  = r_perf_busy;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mode4_tree_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mode4_tree_sequencer
//  Brief    : Self-checking bench for mode4_tree_sequencer: table of directed
//             jobs, a mid-job reset sequence and random jobs, all compared
//             against a timeline model built from the job rules, plus a
//             behavioural adder tree driven by the run enables.
//  Options  : MODE4_TREE_SEQ_PERF_EN also checks the performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mode4_tree_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] num_groups;
    logic       in_valid;
    logic       in_ready;
    logic       stage2_run;
    logic       stage1_run;
    logic       stage0_run;
    logic       tree_clear;
    logic       busy;
    logic       done;
    logic [7:0] groups_accepted;
`ifdef MODE4_TREE_SEQ_PERF_EN
    logic [15:0] perf_busy_cycles;
    logic [15:0] perf_stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int prev_groups = 0;

    // Words presented on the tree inputs and a behavioural model of the tree
    int w0, w1, w2, w3;
    int p0, p1, s_mid, acc;

    always #5 clk = ~clk;

    mode4_tree_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .num_groups      (num_groups),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .stage2_run      (stage2_run),
        .stage1_run      (stage1_run),
        .stage0_run      (stage0_run),
        .tree_clear      (tree_clear),
        .busy            (busy),
        .done            (done),
        .groups_accepted (groups_accepted)
`ifdef MODE4_TREE_SEQ_PERF_EN
        ,
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    // Adder tree datapath driven only by the sequencer enables
    always @(posedge clk) begin
        if (tree_clear === 1'b1) begin
            p0 <= 0; p1 <= 0; s_mid <= 0; acc <= 0;
        end else begin
            if (stage2_run === 1'b1) begin
                p0 <= w0 + w1;
                p1 <= w2 + w3;
            end
            if (stage1_run === 1'b1) s_mid <= p0 + p1;
            if (stage0_run === 1'b1) acc <= acc + s_mid;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ctrl_now();
        return {25'd0, in_ready, stage2_run, stage1_run, stage0_run, tree_clear, busy, done};
    endfunction

    // Run one job starting now (just after a posedge) and check every cycle
    task automatic run_job(input int n, input logic [15:0] pbits, input int plen,
                           input int x0, input int x1, input int exp_done, input int exp_stall);
        bit iv [1024];
        bit rdy[1024];
        bit a2 [1024];
        bit a1 [1024];
        bit a0 [1024];
        int r, k, acc_n, tl, done_r, stalls, cnt, seen_done, exp_sum;
        logic [31:0] exp_ctrl;
        for (int i = 0; i < 1024; i++) begin
            iv[i] = 1'($urandom_range(0, 1));
            rdy[i] = 0; a2[i] = 0; a1[i] = 0; a0[i] = 0;
        end
        // Timeline: clear at +1, feed from +2; each accepted group lands in
        // the three tree levels on consecutive cycles; done 3 after the last
        acc_n = 0; tl = 0; r = 2; k = 0; stalls = 0;
        while (acc_n < n) begin
            bit v;
            v = (k < plen) ? pbits[k] : 1'b1;
            iv[r] = v; rdy[r] = 1;
            if (v) begin
                a2[r] = 1; a1[r+1] = 1; a0[r+2] = 1;
                acc_n++; tl = r;
            end else begin
                stalls++;
            end
            r++; k++;
        end
        done_r = (n == 0) ? 2 : tl + 3;

        cnt = 0; seen_done = -1; exp_sum = 0;
        for (int c = 0; c <= done_r + 1; c++) begin
            start      = (c == 0) || (((c == x0) || (c == x1)) && (c >= 1) && (c <= done_r));
            num_groups = (c == 0) ? 8'(n) : 8'($urandom);
            in_valid   = iv[c];
            w0 = $urandom_range(0, 1000); w1 = $urandom_range(0, 1000);
            w2 = $urandom_range(0, 1000); w3 = $urandom_range(0, 1000);
            if (a2[c]) exp_sum += w0 + w1 + w2 + w3;
            @(negedge clk);
            exp_ctrl = {25'd0, rdy[c], a2[c], a1[c], a0[c], 1'(c == 1),
                        1'((c >= 1) && (c <= done_r)), 1'(c == done_r)};
            check("ctrl{rdy,s2,s1,s0,clr,busy,done}", ctrl_now(), exp_ctrl);
            check("groups_accepted", {24'd0, groups_accepted}, (c == 0) ? prev_groups : cnt);
            if (done === 1'b1) seen_done = c;
            if (c == done_r) check("tree_sum", acc, exp_sum);
`ifdef MODE4_TREE_SEQ_PERF_EN
            if (c == done_r + 1) begin
                check("perf_busy_cycles", {16'd0, perf_busy_cycles}, done_r);
                check("perf_stall_cycles", {16'd0, perf_stall_cycles}, stalls);
                if (exp_stall >= 0) check("perf_stall_table", {16'd0, perf_stall_cycles}, exp_stall);
            end
`endif
            if (a2[c]) cnt++;
            @(posedge clk); #1;
        end
        if (exp_done >= 0) check("done_cycle", seen_done, exp_done);
        prev_groups = n;
        start = 0;
    endtask

    typedef struct {
        int          n;
        logic [15:0] pat;
        int          plen;
        int          x0;
        int          x1;
        int          exp_done;
        int          exp_stall;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // n, valid pattern (bit k = k-th feed cycle), length, extra starts, done, stalls
        vecs[0] = '{n: 4,   pat: 16'h0000, plen: 0, x0: -1, x1: -1, exp_done: 8,   exp_stall: 0};
        vecs[1] = '{n: 4,   pat: 16'h002D, plen: 6, x0: -1, x1: -1, exp_done: 10,  exp_stall: 2};
        vecs[2] = '{n: 0,   pat: 16'h0000, plen: 0, x0: -1, x1: -1, exp_done: 2,   exp_stall: 0};
        vecs[3] = '{n: 8,   pat: 16'h0000, plen: 0, x0: 3,  x1: 9,  exp_done: 12,  exp_stall: 0};
        vecs[4] = '{n: 255, pat: 16'h0000, plen: 0, x0: -1, x1: -1, exp_done: 259, exp_stall: 0};
        vecs[5] = '{n: 1,   pat: 16'h0000, plen: 0, x0: 5,  x1: -1, exp_done: 5,   exp_stall: 0};

        reset = 0; start = 0; num_groups = 0; in_valid = 0;
        w0 = 0; w1 = 0; w2 = 0; w3 = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_ctrl", ctrl_now(), 32'h04);
        check("reset_groups", {24'd0, groups_accepted}, 0);
`ifdef MODE4_TREE_SEQ_PERF_EN
        check("reset_perf_busy", {16'd0, perf_busy_cycles}, 0);
        check("reset_perf_stall", {16'd0, perf_stall_cycles}, 0);
`endif
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        check("reset_release_ctrl", ctrl_now(), 32'h04);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_ctrl", ctrl_now(), 32'h00);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].n, vecs[i].pat, vecs[i].plen, vecs[i].x0, vecs[i].x1,
                    vecs[i].exp_done, vecs[i].exp_stall);
        end

        // Reset while feeding an N=8 job with two groups already accepted
        start = 1; num_groups = 8; in_valid = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        check("pre_reset_groups", {24'd0, groups_accepted}, 2);
        check("pre_reset_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        reset = 1; in_valid = 1;
        @(negedge clk);
        check("midjob_reset_ctrl", ctrl_now(), 32'h04);
        check("midjob_reset_groups", {24'd0, groups_accepted}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("after_reset_ctrl", ctrl_now(), 32'h00);
        @(posedge clk); #1;
        prev_groups = 0;
        run_job(1, 16'h0000, 0, -1, -1, 5, 0);

        // Random jobs with random stall patterns and stray start pulses
        for (int j = 0; j < 20; j++) begin
            int rn, rl, rx;
            logic [15:0] rp;
            rn = $urandom_range(0, 24);
            rp = 16'($urandom);
            rl = $urandom_range(0, 16);
            rx = $urandom_range(1, 30);
            run_job(rn, rp, rl, rx, -1, -1, -1);
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("idle_gap_ctrl", ctrl_now(), 32'h00);
                @(posedge clk); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mode4_tree_sequencer.md
Name: mode4_tree_sequencer

Overview:
- Controller that sequences the 4-input, 3-stage pipelined FP adder tree ("mode4" reduction) used by the attention layer.
- Takes a job of N four-word groups and clears the tree accumulator. Then accepts groups with a valid/ready handshake and drives the per-stage run enables so that only valid data advances.
- Pulses done once the accumulated result is stable at the tree output.
- Sits between the buffer-read logic (input side) and the adder-tree datapath (enable side).

Parameters:
- CNT_W, 8, width of the group count; max job = 2^CNT_W-1 groups.
- PERF_W, 16, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- num_groups  in  CNT_W  number of 4-word groups in the job; sampled with start.
- in_valid  in  1  upstream presents a group on the tree inputs this cycle.
- in_ready  out  1  sequencer accepts a group this cycle.
- stage2_run  out  1  enable for the first adder level (input pair registers).
- stage1_run  out  1  enable for the second adder level.
- stage0_run  out  1  enable for the accumulator/output register.
- tree_clear  out  1  active-high clear to the adder tree registers.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse; tree output holds the final sum.
- groups_accepted  out  CNT_W  groups accepted so far in the current job.

Behaviour:
- States: IDLE, CLEAR, FEED, DRAIN, DONE. State and all registered outputs are updated on posedge clk.
- Reset (reset==0), taking priority in any state, including mid-job:
  - state=IDLE.
  - in_ready=0, stage1_run=0, stage0_run=0, busy=0, done=0, groups_accepted=0.
  - Pipe flags v1=0, v0=0.
  - tree_clear=1 (registered reset value); it deasserts on the first cycle after reset is released.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 latches num_groups into n_q, clears groups_accepted, and goes to CLEAR.
- CLEAR (exactly 1 cycle):
  - tree_clear=1, busy=1.
  - Next state is FEED if n_q!=0, otherwise DONE (zero-length job gives result 0).
- FEED:
  - in_ready=1 (decoded from state).
  - accept = in_valid & in_ready.
  - stage2_run = accept (combinational).
  - v1 <= accept; stage1_run = v1.
  - v0 <= v1; stage0_run = v0.
  - Bubbles (in_valid=0) propagate as run=0 at every stage. The tree never adds stale register contents.
  - Each accept increments groups_accepted.
  - An accept with groups_accepted==n_q-1 moves to DRAIN, so in_ready drops the following cycle.
- DRAIN:
  - in_ready=0. v1/v0 keep shifting (with v1 <= 0).
  - When v1==0, go to DONE. The last stage0_run occurs in this final DRAIN cycle.
- DONE (1 cycle):
  - done=1, busy=1. Next state is IDLE.
  - start in DONE is ignored.
- Latency:
  - With the last accept at cycle T: stage1_run at T+1, stage0_run at T+2, done at T+3.
  - Start at S with no stalls: first accept at S+2; done at S+N+4.
- start while busy is ignored. num_groups changes after start have no effect.
- Counters: groups_accepted never wraps within a job, because n_q is at most 2^CNT_W-1.

Optional Feature:
- Macro MODE4_TREE_SEQ_PERF_EN.
- When defined, adds two output ports:
  - perf_busy_cycles [PERF_W-1:0]: counts cycles with busy=1.
  - perf_stall_cycles [PERF_W-1:0]: counts FEED cycles with in_valid=0.
  - Both counters clear on the start accept and saturate at all-ones. Both reset to 0.
- When not defined, these ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package mode4_seq_pkg holds the state encoding (IDLE=0, CLEAR=1, FEED=2, DRAIN=3, DONE=4, 3-bit) and the TREE_DEPTH=3 constant.
- One natural sub-module, mode4_run_pipe: a valid shift register taking accept and producing stage1_run/stage0_run, with a synchronous active-low clear.

Test Plan:
- N=4, in_valid constantly 1, start at cycle 0:
  - tree_clear=1 at cycle 1.
  - in_ready=1 for cycles 2-5.
  - stage2_run 2-5, stage1_run 3-6, stage0_run 4-7.
  - done at cycle 8; tree sum equals the reference model.
- N=4, in_valid pattern 1,0,1,1,0,1 from the first FEED cycle:
  - exactly 4 pulses on each stage run.
  - stage1/stage0 reproduce the pattern delayed by 1 and 2 cycles.
  - done 3 cycles after the last accept; stall counter=2 when the macro is defined.
- N=0:
  - tree_clear at cycle 1, done at cycle 2.
  - no run pulses, in_ready never high.
- start pulses at cycles 3 and 9 during an N=8 job: ignored, groups_accepted ends at 8, single done.
- reset=0 asserted during FEED with groups_accepted=2:
  - next cycle all outputs 0 and tree_clear=1.
  - after release, a new job with N=1 completes with done at start+5.
- N=255 without stalls: groups_accepted reaches 255 without wrap; done at start+259.
